// File: rtl/gap_collision.sv
// -----------------------------------------------------------------------------
// gap_collision
//
// Per-pixel collision and scoring monitor for the Wild Cube playfield.
// Watches the pixel stream from the horizontal-line renderers and the player
// cube and, once per frame, decides whether the cube hit a line or passed
// cleanly through its gap. Drives the line-motion control (stop), the line
// blink gate (flash), a sticky hit flag and a saturating 8-bit score.
//
// Ports
//   clk           in  1  pixel clock
//   reset         in  1  asynchronous, active-high; clears all state
//   frame         in  1  frame strobe level; rising edge detected here
//   start_machine in  1  game enable (level)
//   active        in  1  current pixel is in the visible region
//   band          in  1  current row lies inside the line band
//   h_line        in  1  a line pixel is lit at the current position
//   cube          in  1  a cube pixel is lit at the current position
//   stop          out 1  1 = line motion runs, 0 = frozen (line flashes)
//   flash         out 1  blink gate for the line renderers
//   hit           out 1  sticky collision indicator
//   score         out 8  count of clean passes, saturating at 255
//
// All outputs are registered. Every frame-level decision is taken in the
// single clock cycle where the rising edge of frame is seen (fr_s), using the
// accumulators of the frame that is just ending.
// -----------------------------------------------------------------------------
module gap_collision (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame,
    input  logic       start_machine,
    input  logic       active,
    input  logic       band,
    input  logic       h_line,
    input  logic       cube,
    output logic       stop,
    output logic       flash,
    output logic       hit,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2
    } state_t;

    // Saturating score increment: 255 stays at 255.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'd255) begin
            result = 8'd255;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    // -------------------------------------------------------------------------
    // Internal state
    // -------------------------------------------------------------------------
    logic       frame_q_r;
    logic       ov_r;
    logic       inb_r;
    logic       inb_prev_r;
    logic [6:0] fc_r;
    state_t     state_r;
    logic       stop_r;
    logic       flash_r;
    logic       hit_r;
    logic [7:0] score_r;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic       fr_s;
    logic       ov_pix_s;
    logic       inb_pix_s;
    logic       pass_s;
    logic [6:0] fc_inc_s;
    logic       fc_last_s;

    assign fr_s      = frame & ~frame_q_r;
    // Pixels outside the visible region never count, even if line and cube
    // are both lit there.
    assign ov_pix_s  = active & h_line & cube;
    assign inb_pix_s = active & band & cube;
    // Clean pass: cube was inside the band the frame before and has left it
    // in the frame that is ending now.
    assign pass_s    = inb_prev_r & ~inb_r;
    assign fc_inc_s  = fc_r + 7'd1;
    assign fc_last_s = (fc_r == 7'd127);

    assign stop  = stop_r;
    assign flash = flash_r;
    assign hit   = hit_r;
    assign score = score_r;

    // Frame strobe delay register for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q_r <= 1'b0;
        end else begin
            frame_q_r <= frame;
        end
    end

    // Per-frame overlap / in-band accumulators. The pixel seen in the fr_s
    // cycle already belongs to the new frame, so it is loaded instead of
    // clearing to zero; the decision logic still sees the old-frame value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov_r       <= 1'b0;
            inb_r      <= 1'b0;
            inb_prev_r <= 1'b0;
        end else if (fr_s) begin
            ov_r       <= ov_pix_s;
            inb_r      <= inb_pix_s;
            inb_prev_r <= inb_r;
        end else begin
            ov_r       <= ov_r | ov_pix_s;
            inb_r      <= inb_r | inb_pix_s;
            inb_prev_r <= inb_prev_r;
        end
    end

    // Game state machine with registered outputs; advances only on fr_s.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            stop_r  <= 1'b0;
            flash_r <= 1'b1;
            hit_r   <= 1'b0;
            score_r <= 8'd0;
            fc_r    <= 7'd0;
        end else if (fr_s) begin
            case (state_r)
                ST_IDLE: begin
                    flash_r <= 1'b1;
                    hit_r   <= 1'b0;
                    fc_r    <= 7'd0;
                    if (start_machine) begin
                        state_r <= ST_RUN;
                        stop_r  <= 1'b1;
                        score_r <= 8'd0;
                    end else begin
                        state_r <= ST_IDLE;
                        stop_r  <= 1'b0;
                    end
                end

                ST_RUN: begin
                    flash_r <= 1'b1;
                    if (!start_machine) begin
                        state_r <= ST_IDLE;
                        stop_r  <= 1'b0;
                        hit_r   <= 1'b0;
                    end else if (ov_r) begin
                        // Collision outranks a pass seen in the same frame.
                        state_r <= ST_HIT;
                        stop_r  <= 1'b0;
                        hit_r   <= 1'b1;
                        fc_r    <= 7'd0;
                    end else begin
                        state_r <= ST_RUN;
                        stop_r  <= 1'b1;
                        hit_r   <= 1'b0;
                        if (pass_s) begin
                            score_r <= sat_inc(score_r);
                        end else begin
                            score_r <= score_r;
                        end
                    end
                end

                ST_HIT: begin
                    // start_machine is deliberately ignored while flashing.
                    stop_r <= 1'b0;
                    if (fc_last_s) begin
                        state_r <= ST_IDLE;
                        hit_r   <= 1'b0;
                        flash_r <= 1'b1;
                        fc_r    <= 7'd0;
                    end else begin
                        state_r <= ST_HIT;
                        hit_r   <= 1'b1;
                        fc_r    <= fc_inc_s;
                        // Blink: on for counts 0..7, off for 8..15, and so on.
                        flash_r <= ~fc_inc_s[3];
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    stop_r  <= 1'b0;
                    flash_r <= 1'b1;
                    hit_r   <= 1'b0;
                    fc_r    <= 7'd0;
                end
            endcase
        end else begin
            state_r <= state_r;
            stop_r  <= stop_r;
            flash_r <= flash_r;
            hit_r   <= hit_r;
            score_r <= score_r;
            fc_r    <= fc_r;
        end
    end

endmodule

// File: tb/tb_gap_collision.sv
// -----------------------------------------------------------------------------
// tb_gap_collision
//
// Self-checking bench for gap_collision. Each scenario task drives frames of
// pixel activity; expected {stop, flash, hit, score} words are pushed to a
// queue as the deciding frame edge is driven and popped/compared once the
// DUT has clocked that edge.
// -----------------------------------------------------------------------------
module tb_gap_collision;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame;
    logic       start_machine;
    logic       active;
    logic       band;
    logic       h_line;
    logic       cube;
    logic       stop;
    logic       flash;
    logic       hit;
    logic [7:0] score;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_v;
    logic [10:0] got_v;

    // Body kinds for frame_body
    localparam int K_EMPTY   = 0; // no cube pixels
    localparam int K_BAND    = 1; // cube inside band, no overlap
    localparam int K_OVL     = 2; // cube in band plus one overlap pixel
    localparam int K_OFFVIS  = 3; // overlap outside the visible region
    localparam int K_OVL_OUT = 4; // overlap with cube outside band

    always #5 clk = ~clk;

    gap_collision dut (
        .clk           (clk),
        .reset         (reset),
        .frame         (frame),
        .start_machine (start_machine),
        .active        (active),
        .band          (band),
        .h_line        (h_line),
        .cube          (cube),
        .stop          (stop),
        .flash         (flash),
        .hit           (hit),
        .score         (score)
    );

    function automatic logic [10:0] pk(input logic s, input logic f, input logic h, input logic [7:0] sc);
        return {s, f, h, sc};
    endfunction

    task automatic pix(input logic a, input logic b, input logic h, input logic c);
        active = a;
        band   = b;
        h_line = h;
        cube   = c;
    endtask

    // Raise frame (producing one fr cycle) and return just after that edge.
    task automatic frame_start(input bit ovl_at_fr);
        @(negedge clk);
        frame = 1'b1;
        if (ovl_at_fr) pix(1'b1, 1'b1, 1'b1, 1'b1);
        else           pix(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Rest of a frame: frame stays high 'hold' more cycles, then pixels.
    task automatic frame_body(input int kind, input int hold);
        @(negedge clk);
        pix(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (hold) @(negedge clk);
        frame = 1'b0;
        case (kind)
            K_BAND:    begin pix(1'b1, 1'b1, 1'b0, 1'b1); repeat (2) @(negedge clk); end
            K_OVL:     begin pix(1'b1, 1'b1, 1'b0, 1'b1); @(negedge clk); pix(1'b1, 1'b1, 1'b1, 1'b1); @(negedge clk); end
            K_OFFVIS:  begin pix(1'b0, 1'b1, 1'b1, 1'b1); repeat (2) @(negedge clk); end
            K_OVL_OUT: begin pix(1'b1, 1'b0, 1'b1, 1'b1); @(negedge clk); end
            default:   ;
        endcase
        pix(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; frame = 1'b0; start_machine = 1'b0;
        pix(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 8'd0));
        got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL reset_hold: got %b expected %b", got_v, exp_v); end

        reset = 1'b0; start_machine = 1'b1;
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 8'd0));
        frame_start(1'b0);
        got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL reset_run_entry: got %b expected %b", got_v, exp_v); end

        // Build score up to 5 with band / empty frame pairs.
        for (int i = 1; i <= 10; i++) begin
            exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 8'(i / 2)));
            frame_body((i % 2 == 1) ? K_BAND : K_EMPTY, 1);
            frame_start(1'b0);
            got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL reset_buildup[%0d]: got %b expected %b", i, got_v, exp_v); end
        end

        // Mid-frame reset with the cube already seen in band.
        frame_body(K_BAND, 1);
        #2;
        reset = 1'b1;
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 8'd0));
        #1;
        got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL reset_async: got %b expected %b", got_v, exp_v); end
        @(negedge clk);
        reset = 1'b0;

        // Entry after release, then a frame that must not count a pass.
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 8'd0));
            if (i == 1) frame_body(K_EMPTY, 1);
            frame_start(1'b0);
            got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL reset_release[%0d]: got %b expected %b", i, got_v, exp_v); end
        end
    endtask

    task automatic test_clean_pass();
        int          kinds[5]  = '{K_BAND, K_BAND, K_BAND, K_EMPTY, K_OFFVIS};
        logic [7:0]  scores[5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(pk(1'b1, 1'b1, 1'b0, scores[i]));
            frame_body(kinds[i], (i == 1) ? 20 : 1);
            frame_start(1'b0);
            got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL clean_pass[%0d]: got %b expected %b", i, got_v, exp_v); end
        end
    endtask

    task automatic test_collision();
        logic [6:0] fck;
        exp_q.push_back(pk(1'b0, 1'b1, 1'b1, 8'd1));
        frame_body(K_OVL, 1);
        frame_start(1'b0);
        got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL collision_entry: got %b expected %b", got_v, exp_v); end

        for (int k = 1; k <= 128; k++) begin
            if (k == 20) start_machine = 1'b0;
            if (k == 40) start_machine = 1'b1;
            fck = 7'(k);
            if (k <= 127) exp_q.push_back(pk(1'b0, ~fck[3], 1'b1, 8'd1));
            else          exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 8'd1));
            frame_body((k == 60) ? K_OVL : K_EMPTY, (k == 5) ? 20 : 1);
            frame_start(1'b0);
            got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL collision_frame[%0d]: got %b expected %b", k, got_v, exp_v); end
        end
    endtask

    task automatic test_priority();
        int          kinds[5] = '{K_EMPTY, K_BAND, K_EMPTY, K_BAND, K_OVL_OUT};
        logic [10:0] exps[5];
        exps[0] = pk(1'b1, 1'b1, 1'b0, 8'd0);
        exps[1] = pk(1'b1, 1'b1, 1'b0, 8'd0);
        exps[2] = pk(1'b1, 1'b1, 1'b0, 8'd1);
        exps[3] = pk(1'b1, 1'b1, 1'b0, 8'd1);
        exps[4] = pk(1'b0, 1'b1, 1'b1, 8'd1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exps[i]);
            frame_body(kinds[i], 1);
            frame_start(1'b0);
            got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL priority[%0d]: got %b expected %b", i, got_v, exp_v); end
        end

        // Reset in the middle of HIT.
        frame_body(K_EMPTY, 1);
        #2;
        reset = 1'b1;
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 8'd0));
        #1;
        got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL priority_hit_reset: got %b expected %b", got_v, exp_v); end
        @(negedge clk);
        reset = 1'b0;

        // Overlap pixel exactly in the fr cycle belongs to the new frame.
        for (int i = 0; i < 3; i++) begin
            if (i == 2) exp_q.push_back(pk(1'b0, 1'b1, 1'b1, 8'd0));
            else        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 8'd0));
            if (i > 0) frame_body(K_EMPTY, 1);
            frame_start(i == 1);
            got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL overlap_at_fr[%0d]: got %b expected %b", i, got_v, exp_v); end
        end

        #2;
        reset = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        pix(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_enable_drop();
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 8'd0));
        frame_start(1'b0);
        got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL enable_entry: got %b expected %b", got_v, exp_v); end

        for (int i = 1; i <= 15; i++) begin
            exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 8'(i / 2)));
            frame_body((i % 2 == 1) ? K_BAND : K_EMPTY, 1);
            frame_start(1'b0);
            got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL enable_buildup[%0d]: got %b expected %b", i, got_v, exp_v); end
        end

        // Drop enable on a frame that would otherwise be a pass.
        for (int i = 0; i < 4; i++) begin
            start_machine = (i >= 2) ? 1'b1 : 1'b0;
            case (i)
                0, 1:    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 8'd7));
                2:       exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 8'd0));
                default: exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 8'd1));
            endcase
            frame_body((i == 2) ? K_BAND : K_EMPTY, 1);
            frame_start(1'b0);
            got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL enable_drop[%0d]: got %b expected %b", i, got_v, exp_v); end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] sc = 8'd1;
        for (int i = 0; i < 520; i++) begin
            if (i % 2 == 1) sc = (sc == 8'd255) ? 8'd255 : sc + 8'd1;
            exp_q.push_back(pk(1'b1, 1'b1, 1'b0, sc));
            frame_body((i % 2 == 0) ? K_BAND : K_EMPTY, 1);
            frame_start(1'b0);
            got_v = {stop, flash, hit, score}; exp_v = exp_q.pop_front(); checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL saturation[%0d]: got %b expected %b", i, got_v, exp_v); end
        end
        checks++;
        if (score !== 8'd255) begin errors++; $display("FAIL saturation_final: got score=%0d expected 255", score); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_pass();
        test_collision();
        test_priority();
        test_enable_drop();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gap_collision.md
# gap_collision

Per-pixel collision and scoring monitor for the Wild Cube playfield. It watches the pixel stream from the horizontal-line renderers and the player cube and decides, once per frame, whether the cube hit a line or passed cleanly through its gap. It drives the game-level `stop` and `flash` controls and keeps an 8-bit score. It sits between the VGA counters/renderers and the line motion logic, and consumes what the line renderers produce.

## Interface
- No parameters; band, flash and hold constants are fixed below.
- `clk` in 1: pixel clock, shared with the horizontal/vertical counters.
- `reset` in 1: asynchronous, active-high; clears all state.
- `frame` in 1: frame strobe level from the vertical counter; the block detects its rising edge internally.
- `start_machine` in 1: game enable, level.
- `active` in 1: current pixel is in the visible region.
- `band` in 1: current row is inside the line band (Y 128..136).
- `h_line` in 1: a line pixel is lit at the current position.
- `cube` in 1: a cube pixel is lit at the current position.
- `stop` out 1: 1 = line motion runs; 0 = frozen, so the line flashes.
- `flash` out 1: blink gate for the line renderers.
- `hit` out 1: sticky collision indicator.
- `score` out 8: count of clean passes, saturating.

## Operation
- Frame edge detection:
  - `frame_q` registers `frame`; `fr = frame & ~frame_q`.
  - All frame-level decisions are made in the cycle where `fr` = 1.
- Per-frame accumulators, cleared on `fr`:
  - `ov`: set by `active & h_line & cube`.
  - `inb`: set by `active & band & cube`.
  - A pixel sampled in the `fr` cycle belongs to the new frame. The accumulator loads that pixel's value rather than clearing to 0.
- `inb_prev` holds the previous frame's `inb`.
- State machine, advancing only on `fr`:
  - IDLE:
    - `stop`=0, `flash`=1, `hit`=0.
    - If `start_machine`=1, go to RUN and clear `score` to 0.
  - RUN:
    - `stop`=1, `flash`=1.
    - If `start_machine`=0, go to IDLE; score is held.
    - Else if `ov`=1, go to HIT, set `hit`=1, clear the frame counter `fc` (7-bit).
    - Else if `inb_prev`=1 and `inb`=0, this is a clean pass: `score` += 1, saturating at 255.
    - `ov` has priority over a pass in the same frame.
  - HIT:
    - `stop`=0.
    - `fc` increments each `fr`.
    - `flash` = ~`fc[3]`, i.e. it toggles every 8 frames and starts at 1.
    - When `fc`=127 and `fr` arrives, go to IDLE, clear `hit`, hold `score`.
    - `start_machine` is ignored in HIT.
- `score` changes only in RUN on a pass; it is cleared only on the IDLE→RUN transition or by reset.

## Timing
- Reset values:
  - state = IDLE, `stop`=0, `flash`=1, `hit`=0, `score`=0.
  - `ov`=`inb`=`inb_prev`=0, `fc`=0, `frame_q`=0.
- All outputs are registered.
- A collision pixel at cycle t sets `ov` at edge t+1. `hit` and `stop` update at the edge ending the next `fr` cycle, so they lag up to one frame.
- A score increment becomes visible one cycle after the deciding `fr` cycle.
- `frame` held high for many cycles produces a single `fr`.
- A `frame` glitch shorter than one `clk` period is not required to be detected.
- Reset asserted mid-frame or mid-HIT immediately forces the reset values, independent of `clk`. After deassertion, the first `fr` only primes `inb_prev`; no pass can be counted until the second `fr` in RUN.
- `inb_prev` updates on every `fr` in every state. The first RUN frame after IDLE can therefore count a pass only if the cube was in the band during the frame before entry.
- Saturation: at `score`=255, further passes leave it at 255.
- Overlap outside `active` is ignored even if `h_line` & `cube`.

## Test plan
- Reset:
  - Stimulus: assert `reset` mid-frame while in RUN with `score`=5.
  - Response: the outputs immediately become `stop`=0, `flash`=1, `hit`=0, `score`=0.
  - After release, a `start_machine` high plus one `fr` gives `stop`=1.
- Clean pass:
  - Stimulus: in RUN, cube pixels inside `band` for 3 frames, none overlapping `h_line`, then cube out of band.
  - Response: `score` goes 0→1 one cycle after the 4th `fr`; `hit` stays 0.
- Collision:
  - Stimulus: in RUN, one pixel with `active`=`h_line`=`cube`=1 at row 130.
  - Response: at the next `fr`, `hit`=1 and `stop`=0.
  - `flash` is 1 for 8 frames, then 0 for 8 frames, and so on.
  - After 128 frames the block is in IDLE with `hit`=0 and score unchanged.
- Priority and boundary:
  - Stimulus: cube leaves the band in the same frame that contains an overlap.
  - Response: HIT is entered and `score` is unchanged.
  - Stimulus: an overlap pixel in the exact `fr` cycle.
  - Response: it is counted in the new frame, and the hit is declared at the following `fr`.
- Saturation:
  - Stimulus: force 260 clean passes.
  - Response: `score`=255 and it holds.
- Enable drop:
  - Stimulus: `start_machine` goes to 0 in RUN with `score`=7.
  - Response: next `fr` → IDLE, `stop`=0, `score`=7.
  - Stimulus: raise `start_machine` again.
  - Response: `score` is cleared to 0 on RUN entry.
  - Stimulus: toggle `start_machine` during HIT.
  - Response: no effect.
